// File: rtl/load_step_sequencer.sv
// Load-group enable sequencer: stepped ramp (up / hold / down) or
// full-load square-wave burst, with optional endless repetition.
module load_step_sequencer #(
  parameter int NUM_GROUPS = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  dut_clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  mode,
  input  logic                  repeat_forever,
  input  logic [CNT_W-1:0]      step_cycles,
  input  logic [CNT_W-1:0]      hold_cycles,
  output logic [NUM_GROUPS-1:0] group_en,
  output logic                  busy,
  output logic [2:0]            state_out,
  output logic                  done,
  output logic [15:0]           iter_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD      = 3'd2,
    RAMP_DOWN = 3'd3,
    BURST     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0]      ONE    = CNT_W'(1);
  localparam logic [NUM_GROUPS-1:0] ALL_ON = '1;

  state_t                state_q, state_d;
  logic [NUM_GROUPS-1:0] en_q, en_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;   // cycles within current step / hold / half-period
  logic [CNT_W-1:0]      per_q, per_d;   // completed burst periods in this iteration
  logic [CNT_W-1:0]      s_q, s_d;       // latched step length, never zero
  logic [CNT_W-1:0]      h_q, h_d;       // latched hold length / period count
  logic                  mode_q, mode_d;
  logic                  rep_q, rep_d;
  logic                  low_q, low_d;   // burst: currently in the all-off half
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [15:0]           iter_q, iter_d;

  logic                  step_end, hold_end, per_end;
  logic [15:0]           iter_inc;
  logic [NUM_GROUPS-1:0] en_up, en_dn;

  // Shifting the thermometer by one keeps the pattern contiguous at all times.
  assign en_up    = {en_q[NUM_GROUPS-2:0], 1'b1};
  assign en_dn    = {1'b0, en_q[NUM_GROUPS-1:1]};
  assign step_end = (cnt_q == s_q - ONE);
  assign hold_end = (cnt_q == h_q - ONE);
  assign per_end  = (per_q == h_q - ONE);
  assign iter_inc = (iter_q == 16'hFFFF) ? iter_q : iter_q + 16'd1;

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    s_d     = s_q;
    h_d     = h_q;
    mode_d  = mode_q;
    rep_d   = rep_q;
    low_d   = low_q;
    done_d  = 1'b0;
    iter_d  = iter_q;

    if (abort) begin
      state_d = IDLE;
      en_d    = '0;
      cnt_d   = '0;
      per_d   = '0;
      low_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            mode_d = mode;
            rep_d  = repeat_forever;
            s_d    = (step_cycles == '0) ? ONE : step_cycles;
            h_d    = (mode && hold_cycles == '0) ? ONE : hold_cycles;
            iter_d = '0;
            cnt_d  = '0;
            per_d  = '0;
            low_d  = 1'b0;
            if (mode) begin
              state_d = BURST;
              en_d    = ALL_ON;
            end else begin
              state_d = RAMP_UP;
              en_d    = {{(NUM_GROUPS-1){1'b0}}, 1'b1};
            end
          end
        end
        RAMP_UP: begin
          if (step_end) begin
            cnt_d = '0;
            if (en_q[NUM_GROUPS-1]) begin
              if (h_q == '0) begin
                state_d = RAMP_DOWN;
                en_d    = en_dn;
              end else begin
                state_d = HOLD;
              end
            end else begin
              en_d = en_up;
            end
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        HOLD: begin
          if (hold_end) begin
            cnt_d   = '0;
            state_d = RAMP_DOWN;
            en_d    = en_dn;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        RAMP_DOWN: begin
          if (step_end) begin
            cnt_d = '0;
            if (!en_q[1]) begin
              // Last group turning off: iteration complete.
              iter_d = iter_inc;
              if (rep_q) begin
                state_d = RAMP_UP;
                en_d    = {{(NUM_GROUPS-1){1'b0}}, 1'b1};
              end else begin
                state_d = IDLE;
                en_d    = '0;
                done_d  = 1'b1;
              end
            end else begin
              en_d = en_dn;
            end
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        BURST: begin
          if (step_end) begin
            cnt_d = '0;
            if (!low_q) begin
              low_d = 1'b1;
              en_d  = '0;
            end else if (per_end) begin
              iter_d = iter_inc;
              per_d  = '0;
              if (rep_q) begin
                low_d = 1'b0;
                en_d  = ALL_ON;
              end else begin
                state_d = IDLE;
                low_d   = 1'b0;
                done_d  = 1'b1;
              end
            end else begin
              per_d = per_q + ONE;
              low_d = 1'b0;
              en_d  = ALL_ON;
            end
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: begin
          state_d = IDLE;
          en_d    = '0;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge dut_clk) begin
    if (reset) begin
      state_q <= IDLE;
      en_q    <= '0;
      cnt_q   <= '0;
      per_q   <= '0;
      s_q     <= ONE;
      h_q     <= '0;
      mode_q  <= 1'b0;
      rep_q   <= 1'b0;
      low_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      s_q     <= s_d;
      h_q     <= h_d;
      mode_q  <= mode_d;
      rep_q   <= rep_d;
      low_q   <= low_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      iter_q  <= iter_d;
    end
  end

  assign group_en   = en_q;
  assign busy       = busy_q;
  assign state_out  = state_q;
  assign done       = done_q;
  assign iter_count = iter_q;

endmodule
